// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the pipelined MIPS control unit: opcodes, aluop codes
// and the layout of the control word carried through ID/EX.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam int ALU_CODE_W = 3;

    typedef enum logic [ALU_CODE_W-1:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_FUNCT = 3'b010,
        ALU_AND   = 3'b011,
        ALU_OR    = 3'b100,
        ALU_SLT   = 3'b101
    } aluop_e;

    // Control word layout: single-bit flags above a 3-bit aluop field.
    localparam int C_ALUOP_LO = 0;
    localparam int C_ALUOP_HI = ALU_CODE_W - 1;
    localparam int C_JUMP     = 3;
    localparam int C_BNE      = 4;
    localparam int C_BRANCH   = 5;
    localparam int C_MEMWRITE = 6;
    localparam int C_MEMREAD  = 7;
    localparam int C_REGWRITE = 8;
    localparam int C_MEMTOREG = 9;
    localparam int C_ALUSRC   = 10;
    localparam int C_REGDST   = 11;
    localparam int CTRL_W     = 12;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control word, illegal-opcode flag and whether
// the instruction reads rt as a source operand.
module ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]        opcode,
    output logic [CTRL_W-1:0] ctrl,
    output logic              illegal,
    output logic              uses_rt
);

    always_comb begin
        ctrl    = CTRL_BUBBLE;
        illegal = 1'b0;
        uses_rt = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                ctrl[C_REGDST]                = 1'b1;
                ctrl[C_REGWRITE]              = 1'b1;
                ctrl[C_ALUOP_HI:C_ALUOP_LO]   = ALU_FUNCT;
                uses_rt                       = 1'b1;
            end
            OP_LW: begin
                ctrl[C_ALUSRC]                = 1'b1;
                ctrl[C_MEMTOREG]              = 1'b1;
                ctrl[C_REGWRITE]              = 1'b1;
                ctrl[C_MEMREAD]               = 1'b1;
                ctrl[C_ALUOP_HI:C_ALUOP_LO]   = ALU_ADD;
            end
            OP_SW: begin
                ctrl[C_ALUSRC]                = 1'b1;
                ctrl[C_MEMWRITE]              = 1'b1;
                ctrl[C_ALUOP_HI:C_ALUOP_LO]   = ALU_ADD;
                uses_rt                       = 1'b1;
            end
            OP_BEQ: begin
                ctrl[C_BRANCH]                = 1'b1;
                ctrl[C_ALUOP_HI:C_ALUOP_LO]   = ALU_SUB;
                uses_rt                       = 1'b1;
            end
            OP_BNE: begin
                ctrl[C_BRANCH]                = 1'b1;
                ctrl[C_BNE]                   = 1'b1;
                ctrl[C_ALUOP_HI:C_ALUOP_LO]   = ALU_SUB;
                uses_rt                       = 1'b1;
            end
            OP_ADDI: begin
                ctrl[C_ALUSRC]                = 1'b1;
                ctrl[C_REGWRITE]              = 1'b1;
                ctrl[C_ALUOP_HI:C_ALUOP_LO]   = ALU_ADD;
            end
            OP_ANDI: begin
                ctrl[C_ALUSRC]                = 1'b1;
                ctrl[C_REGWRITE]              = 1'b1;
                ctrl[C_ALUOP_HI:C_ALUOP_LO]   = ALU_AND;
            end
            OP_ORI: begin
                ctrl[C_ALUSRC]                = 1'b1;
                ctrl[C_REGWRITE]              = 1'b1;
                ctrl[C_ALUOP_HI:C_ALUOP_LO]   = ALU_OR;
            end
            OP_SLTI: begin
                ctrl[C_ALUSRC]                = 1'b1;
                ctrl[C_REGWRITE]              = 1'b1;
                ctrl[C_ALUOP_HI:C_ALUOP_LO]   = ALU_SLT;
            end
            OP_J: begin
                ctrl[C_JUMP]                  = 1'b1;
            end
            default: begin
                illegal                       = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: decodes ID, carries control through ID/EX, EX/MEM and
// MEM/WB, inserts load-use stalls/bubbles and honours flush requests.
module ctrl_pipe_unit
    import mips_ctrl_pkg::*;
#(
    parameter int REG_W     = 5,
    parameter int ALUOP_W   = 3,
    parameter int HAZARD_EN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         id_opcode,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic               flush,
    output logic               stall,
    output logic               ex_regdst,
    output logic               ex_alusrc,
    output logic               ex_branch,
    output logic               ex_bne,
    output logic               ex_jump,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic [REG_W-1:0]   ex_rt,
    output logic               ex_memread,
    output logic               ex_memwrite,
    output logic               ex_memtoreg,
    output logic               ex_regwrite,
    output logic               mem_memread,
    output logic               mem_memwrite,
    output logic               mem_memtoreg,
    output logic               mem_regwrite,
    output logic               wb_memtoreg,
    output logic               wb_regwrite,
    output logic               illegal_op
);

    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_illegal;
    logic              dec_uses_rt;
    logic [CTRL_W-1:0] idex_ctrl;
    logic [REG_W-1:0]  idex_rt;
    logic              hazard;
    logic              kill;

    ctrl_decode u_dec (
        .opcode  (id_opcode),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal),
        .uses_rt (dec_uses_rt)
    );

    // rt of a load in EX only matters if the ID instruction actually reads it.
    assign hazard = idex_ctrl[C_MEMREAD] && (idex_rt != '0) &&
                    ((idex_rt == id_rs) || (dec_uses_rt && (idex_rt == id_rt)));
    assign stall  = (HAZARD_EN != 0) && hazard && !flush;
    assign kill   = stall || flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_ctrl <= CTRL_BUBBLE;
            idex_rt   <= '0;
        end else if (kill) begin
            idex_ctrl <= CTRL_BUBBLE;
            idex_rt   <= '0;
        end else begin
            idex_ctrl <= dec_ctrl;
            idex_rt   <= id_rt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            mem_memtoreg <= 1'b0;
            mem_regwrite <= 1'b0;
            wb_memtoreg  <= 1'b0;
            wb_regwrite  <= 1'b0;
        end else begin
            mem_memread  <= idex_ctrl[C_MEMREAD];
            mem_memwrite <= idex_ctrl[C_MEMWRITE];
            mem_memtoreg <= idex_ctrl[C_MEMTOREG];
            mem_regwrite <= idex_ctrl[C_REGWRITE];
            wb_memtoreg  <= mem_memtoreg;
            wb_regwrite  <= mem_regwrite;
        end
    end

    // Sticky: only an illegal word that genuinely enters EX counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_op <= 1'b0;
        else if (dec_illegal && !kill)
            illegal_op <= 1'b1;
    end

    assign ex_regdst   = idex_ctrl[C_REGDST];
    assign ex_alusrc   = idex_ctrl[C_ALUSRC];
    assign ex_branch   = idex_ctrl[C_BRANCH];
    assign ex_bne      = idex_ctrl[C_BNE];
    assign ex_jump     = idex_ctrl[C_JUMP];
    assign ex_aluop    = ALUOP_W'(idex_ctrl[C_ALUOP_HI:C_ALUOP_LO]);
    assign ex_rt       = idex_rt;
    assign ex_memread  = idex_ctrl[C_MEMREAD];
    assign ex_memwrite = idex_ctrl[C_MEMWRITE];
    assign ex_memtoreg = idex_ctrl[C_MEMTOREG];
    assign ex_regwrite = idex_ctrl[C_REGWRITE];

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Scoreboard bench for ctrl_pipe_unit: driver queues expected ID/EX words,
// monitor checks EX, MEM and WB outputs against them every clock.
module tb_ctrl_pipe_unit;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
    localparam logic [5:0] ANDI = 6'b001100, ORI = 6'b001101, SLTI = 6'b001010;
    localparam logic [5:0] J = 6'b000010, BAD = 6'b111111;

    typedef struct {
        logic [11:0] w;
        logic [4:0]  rt;
        logic        ill;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] id_opcode = '0;
    logic [4:0] id_rs = '0, id_rt = '0;
    logic       flush = 1'b0;

    logic       stall, ex_regdst, ex_alusrc, ex_branch, ex_bne, ex_jump;
    logic [2:0] ex_aluop;
    logic [4:0] ex_rt;
    logic       ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite;
    logic       mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite;
    logic       wb_memtoreg, wb_regwrite, illegal_op;

    logic       nh_stall;
    logic [2:0] nh_aluop;
    logic [4:0] nh_rt;
    logic [13:0] nh_bits;

    int n_cmp = 0;
    int n_err = 0;
    exp_t sbq[$];
    logic ill_sticky = 1'b0;

    always #5 clk = ~clk;

    ctrl_pipe_unit #(.REG_W(5), .ALUOP_W(3), .HAZARD_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .flush(flush), .stall(stall), .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc),
        .ex_branch(ex_branch), .ex_bne(ex_bne), .ex_jump(ex_jump), .ex_aluop(ex_aluop),
        .ex_rt(ex_rt), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .mem_memread(mem_memread),
        .mem_memwrite(mem_memwrite), .mem_memtoreg(mem_memtoreg), .mem_regwrite(mem_regwrite),
        .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite), .illegal_op(illegal_op)
    );

    ctrl_pipe_unit #(.REG_W(5), .ALUOP_W(3), .HAZARD_EN(0)) dut_nh (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .flush(flush), .stall(nh_stall), .ex_regdst(nh_bits[0]), .ex_alusrc(nh_bits[1]),
        .ex_branch(nh_bits[2]), .ex_bne(nh_bits[3]), .ex_jump(nh_bits[4]), .ex_aluop(nh_aluop),
        .ex_rt(nh_rt), .ex_memread(nh_bits[5]), .ex_memwrite(nh_bits[6]),
        .ex_memtoreg(nh_bits[7]), .ex_regwrite(nh_bits[8]), .mem_memread(nh_bits[9]),
        .mem_memwrite(nh_bits[10]), .mem_memtoreg(nh_bits[11]), .mem_regwrite(nh_bits[12]),
        .wb_memtoreg(nh_bits[13]), .wb_regwrite(), .illegal_op()
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Hand-written decode list; packing {regdst,alusrc,memtoreg,regwrite,
    // memread,memwrite,branch,bne,jump,aluop[2:0]}.
    task automatic exp_ctrl(input logic [5:0] op, output logic [11:0] w, output logic ill);
        ill = 1'b0;
        case (op)
            R:    w = 12'b1_0_0_1_0_0_0_0_0_010;
            LW:   w = 12'b0_1_1_1_1_0_0_0_0_000;
            SW:   w = 12'b0_1_0_0_0_1_0_0_0_000;
            BEQ:  w = 12'b0_0_0_0_0_0_1_0_0_001;
            BNE:  w = 12'b0_0_0_0_0_0_1_1_0_001;
            ADDI: w = 12'b0_1_0_1_0_0_0_0_0_000;
            ANDI: w = 12'b0_1_0_1_0_0_0_0_0_011;
            ORI:  w = 12'b0_1_0_1_0_0_0_0_0_100;
            SLTI: w = 12'b0_1_0_1_0_0_0_0_0_101;
            J:    w = 12'b0_0_0_0_0_0_0_0_1_000;
            default: begin w = '0; ill = 1'b1; end
        endcase
    endtask

    // Called right after a falling edge; exp_st is the hand-derived stall.
    task automatic vec(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic fl, input logic exp_st);
        exp_t e;
        logic [11:0] w;
        logic ill;
        id_opcode = op; id_rs = rs; id_rt = rt; flush = fl;
        #1;
        check("stall", 32'(stall), 32'(exp_st));
        check("stall_hazard_off", 32'(nh_stall), 32'd0);
        exp_ctrl(op, w, ill);
        e.rt = rt;
        if (exp_st || fl) begin
            w = '0; ill = 1'b0; e.rt = '0;
        end
        ill_sticky = ill_sticky | ill;
        e.w = w; e.ill = ill_sticky;
        sbq.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ex"}, 32'({ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
              ex_memwrite, ex_branch, ex_bne, ex_jump, ex_aluop, ex_rt}), 32'd0);
        check({tag, "_mem"}, 32'({mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite}), 32'd0);
        check({tag, "_wb"}, 32'({wb_memtoreg, wb_regwrite}), 32'd0);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_illegal"}, 32'(illegal_op), 32'd0);
    endtask

    // Monitor: EX must match the popped word; MEM/WB lag it by one/two clocks.
    initial begin
        exp_t e;
        logic [11:0] prev_w;
        logic [3:0]  exp_mem;
        logic [1:0]  exp_wb;
        prev_w = '0; exp_mem = '0; exp_wb = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                sbq.delete();
                prev_w = '0; exp_mem = '0; exp_wb = '0;
            end else if (sbq.size() > 0) begin
                e = sbq.pop_front();
                exp_wb  = {exp_mem[1], exp_mem[0]};
                exp_mem = {prev_w[7], prev_w[6], prev_w[9], prev_w[8]};
                prev_w  = e.w;
                check("ex_word", 32'({ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
                      ex_memwrite, ex_branch, ex_bne, ex_jump, ex_aluop}), 32'(e.w));
                check("ex_rt", 32'(ex_rt), 32'(e.rt));
                check("mem_word", 32'({mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite}),
                      32'(exp_mem));
                check("wb_word", 32'({wb_memtoreg, wb_regwrite}), 32'(exp_wb));
                check("illegal_op", 32'(illegal_op), 32'(e.ill));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // Decode sweep with no dependencies.
        vec(R,    1, 2, 0, 0);
        @(negedge clk) vec(LW,   1, 3, 0, 0);
        @(negedge clk) vec(SW,   4, 6, 0, 0);
        @(negedge clk) vec(BEQ,  7, 8, 0, 0);
        @(negedge clk) vec(BNE,  9, 10, 0, 0);
        @(negedge clk) vec(ADDI, 11, 12, 0, 0);
        @(negedge clk) vec(ANDI, 13, 14, 0, 0);
        @(negedge clk) vec(ORI,  15, 16, 0, 0);
        @(negedge clk) vec(SLTI, 17, 18, 0, 0);
        @(negedge clk) vec(J,    19, 20, 0, 0);
        // Load-use through rt: one stall, one bubble, then proceed.
        @(negedge clk) vec(LW,   1, 5, 0, 0);
        @(negedge clk) vec(R,    3, 5, 0, 1);
        @(negedge clk) vec(R,    3, 5, 0, 0);
        // addi does not read rt; lw to r0 never stalls.
        @(negedge clk) vec(LW,   1, 5, 0, 0);
        @(negedge clk) vec(ADDI, 2, 5, 0, 0);
        @(negedge clk) vec(LW,   1, 0, 0, 0);
        @(negedge clk) vec(R,    0, 0, 0, 0);
        // Back-to-back loads: only rs of the second one matters.
        @(negedge clk) vec(LW,   1, 5, 0, 0);
        @(negedge clk) vec(LW,   3, 5, 0, 0);
        @(negedge clk) vec(LW,   5, 6, 0, 1);
        @(negedge clk) vec(LW,   5, 6, 0, 0);
        // Flush beats stall.
        @(negedge clk) vec(LW,   1, 9, 0, 0);
        @(negedge clk) vec(R,    9, 1, 1, 0);
        @(negedge clk) vec(SW,   1, 9, 0, 0);
        // bne reads rt.
        @(negedge clk) vec(LW,   1, 9, 0, 0);
        @(negedge clk) vec(BNE,  1, 9, 0, 1);
        @(negedge clk) vec(BNE,  1, 9, 0, 0);
        // Illegal opcode: flushed copy is ignored, real one sets a sticky flag.
        @(negedge clk) vec(BAD,  1, 2, 1, 0);
        @(negedge clk) vec(R,    1, 2, 0, 0);
        @(negedge clk) vec(BAD,  1, 2, 0, 0);
        @(negedge clk) vec(R,    1, 2, 0, 0);
        @(negedge clk) vec(ORI,  3, 4, 0, 0);
        // Asynchronous reset while a stall is pending.
        @(negedge clk) vec(LW,   1, 5, 0, 0);
        @(negedge clk);
        id_opcode = R; id_rs = 5; id_rt = 1; flush = 1'b0;
        #1;
        check("stall_before_reset", 32'(stall), 32'd1);
        check("illegal_before_reset", 32'(illegal_op), 32'd1);
        rst_n = 1'b0;
        ill_sticky = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        vec(SW,   2, 3, 0, 0);
        @(negedge clk) vec(ADDI, 4, 5, 0, 0);
        @(negedge clk) vec(R,    0, 0, 0, 0);
        @(negedge clk) vec(R,    0, 0, 0, 0);
        @(negedge clk) vec(R,    0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        if (sbq.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_unit.md
# ctrl_pipe_unit

Pipelined control unit for the segmented MIPS core: decodes the ID-stage opcode into a control word and carries it through the ID/EX, EX/MEM and MEM/WB registers. Also detects load-use hazards (stall plus bubble) and applies flush requests. It supersedes the purely combinational main decoder and extends the instruction set with bne, andi, ori and slti. Illegal opcodes produce a safe all-zero bubble instead of X.

## Interface
- REG_W, 5, register-address width
- ALUOP_W, 3, aluop field width (minimum 3)
- HAZARD_EN, 1, 1 = load-use detection active; 0 = stall tied low
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- id_opcode  in  6  opcode of instruction in ID
- id_rs, id_rt  in  REG_W  source fields of instruction in ID
- flush  in  1  datapath request to kill the instruction in ID (taken branch or jump)
- stall  out  1  hold PC and IF/ID; combinational
- ex_regdst, ex_alusrc, ex_branch, ex_bne, ex_jump  out  1 each  ID/EX control bits
- ex_aluop  out  ALUOP_W  ID/EX aluop
- ex_rt  out  REG_W  ID/EX copy of id_rt
- ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite  out  1 each  ID/EX
- mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite  out  1 each  EX/MEM
- wb_memtoreg, wb_regwrite  out  1 each  MEM/WB
- illegal_op  out  1  sticky flag: an illegal opcode reached ID/EX

## Operation
- Decode is a function of id_opcode only. Fields: regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, bne, jump, aluop.
- aluop encodings: 000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt.
- Decode per instruction:
  - R-type 000000: regdst, regwrite, aluop=010.
  - lw 100011: alusrc, memtoreg, regwrite, memread, aluop=000.
  - sw 101011: alusrc, memwrite, aluop=000.
  - beq 000100: branch, aluop=001.
  - bne 000101: branch, bne, aluop=001.
  - addi 001000: alusrc, regwrite, aluop=000.
  - andi 001100: alusrc, regwrite, aluop=011.
  - ori 001101: alusrc, regwrite, aluop=100.
  - slti 001010: alusrc, regwrite, aluop=101.
  - j 000010: jump.
  - Any other opcode: all-zero word, illegal flag raised.
- The instruction uses rt as a source for R-type, sw, beq and bne.
- Hazard condition: ex_memread AND ex_rt != 0 AND (ex_rt == id_rs OR (uses-rt AND ex_rt == id_rt)).
- stall = HAZARD_EN AND hazard AND NOT flush.
- ID/EX load on each clock edge:
  - If stall or flush: load the bubble (all zero; ex_rt = 0).
  - Otherwise: load the decoded word and id_rt.
- EX/MEM and MEM/WB advance every cycle. They are never stalled; flush does not affect them.
- illegal_op sets when an illegal word loads into ID/EX without flush or stall. It clears only on reset.

## Timing
- Reset: every registered output is 0 and illegal_op is 0. Reset is asynchronous on assertion; release is sampled on the clock.
- Latency from id_opcode to ex_* outputs: 1 cycle. To mem_*: 2 cycles. To wb_*: 3 cycles.
- stall is combinational in the same cycle. A lw followed immediately by a dependent instruction gives exactly one stall cycle.
- stall and flush in the same cycle: flush wins. stall = 0 and a bubble is inserted.
- Back-to-back lw, where the second loads the register the first writes: stall only if the second lw's rs matches. The rt of lw is a destination, not a source.
- Reset asserted mid-pipeline: all stages return to bubble immediately. stall drops once the ID/EX register is cleared.

## Structure
- Package mips_ctrl_pkg holds:
  - opcode constants;
  - aluop encodings;
  - control-word field positions and width (CTRL_W);
  - the bubble constant.
- Sub-module ctrl_decode: the combinational opcode-to-control-word decoder, plus the illegal and uses-rt outputs.
- Top module: three pipeline registers, hazard comparator, sticky flag.

## Test plan
- Reset with rst_n=0 mid-stream: all ex/mem/wb outputs read 0 and stall=0 with no clock edge required; illegal_op=0.
- Sequence R-type, lw, sw, beq, bne, addi, andi, ori, slti, j: each ex_* word matches the decode list 1 cycle later; mem_* after 2 cycles and wb_* after 3 cycles.
- lw with rt=5, then R-type with rs=3, rt=5: stall=1 for exactly one cycle, one bubble in ID/EX, then the R-type proceeds.
- lw rt=5, then addi rs=2 rt=5: no stall, because addi does not use rt as a source. Variant with lw rt=0: never stalls.
- Load-use hazard with flush=1 in the same cycle: stall=0 and the ID/EX register is a bubble. Repeat with HAZARD_EN=0: stall stays 0.
- Opcode 111111: ex word all zero and illegal_op=1 on the next edge, staying high until rst_n=0. The same opcode presented together with flush does not set the flag.
